key8_debounce_onehot: RTL and testbench

//  Upstream stage of the 8-to-3 encoder. Samples 8 raw active-high keys,

---
 rtl/key8_debounce_onehot.sv | 167 ++++++++++++++++
 tb/tb_key8_debounce_onehot.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/key8_debounce_onehot.sv
// Key front end for the 8-to-3 encoder: 2-flop sync, single-key debounce, one-hot Din/EN drive.
// Optional auto-repeat strobes while a key is held, enabled by defining KEY_REPEAT_EN.
module key8_debounce_onehot #(
    parameter int DEB_CYCLES    = 20,
    parameter int REPEAT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_raw,
    output logic [7:0] key_onehot,
    output logic       key_en,
    output logic       press_pulse,
    output logic [1:0] key_state
);

    localparam int MAX_CYCLES = (DEB_CYCLES > REPEAT_CYCLES) ? DEB_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_M1  = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [7:0]       sync1_r;
    logic [7:0]       key_sync_r;
    logic [7:0]       cand_r, cand_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       key_onehot_r, onehot_s;
    logic             key_en_r, en_s;
    logic             press_pulse_r, pulse_s;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Next-state and next-output decode; outputs are computed here and registered below.
    always_comb begin
        state_s  = state_r;
        cand_s   = cand_r;
        cnt_s    = cnt_r;
        onehot_s = 8'd0;
        en_s     = 1'b0;
        pulse_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (is_onehot(key_sync_r)) begin
                    state_s = ST_DEBOUNCE;
                    cand_s  = key_sync_r;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            ST_DEBOUNCE: begin
                if (key_sync_r != cand_r) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == DEB_M1) begin
                    state_s  = ST_HELD;
                    onehot_s = cand_r;
                    en_s     = 1'b1;
                    pulse_s  = 1'b1;
                    cnt_s    = {CNT_W{1'b0}};
                end else begin
                    cnt_s    = sat_inc(cnt_r);
                end
            end
            ST_HELD: begin
                // Any change from the accepted key (release, bounce, extra key) drops EN at once.
                if (key_sync_r != cand_r) begin
                    state_s  = ST_RELEASE;
                    cnt_s    = {CNT_W{1'b0}};
                end else begin
                    onehot_s = cand_r;
                    en_s     = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (key_sync_r != 8'd0) begin
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == DEB_M1) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = sat_inc(cnt_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_M1 = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_r, rep_s;
    logic             rep_fire_s;

    // Auto-repeat period counter, live only while staying in HELD.
    always_comb begin
        rep_s      = {CNT_W{1'b0}};
        rep_fire_s = 1'b0;
        if ((state_r == ST_HELD) && (state_s == ST_HELD)) begin
            if (rep_r == REP_M1) begin
                rep_fire_s = 1'b1;
                rep_s      = {CNT_W{1'b0}};
            end else begin
                rep_s      = sat_inc(rep_r);
            end
        end else begin
            rep_s = {CNT_W{1'b0}};
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_r <= {CNT_W{1'b0}};
        end else begin
            rep_r <= rep_s;
        end
    end
`endif

    // Synchroniser, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r       <= 8'd0;
            key_sync_r    <= 8'd0;
            state_r       <= ST_IDLE;
            cand_r        <= 8'd0;
            cnt_r         <= {CNT_W{1'b0}};
            key_onehot_r  <= 8'd0;
            key_en_r      <= 1'b0;
            press_pulse_r <= 1'b0;
        end else begin
            sync1_r       <= key_raw;
            key_sync_r    <= sync1_r;
            state_r       <= state_s;
            cand_r        <= cand_s;
            cnt_r         <= cnt_s;
            key_onehot_r  <= onehot_s;
            key_en_r      <= en_s;
`ifdef KEY_REPEAT_EN
            press_pulse_r <= pulse_s | rep_fire_s;
`else
            press_pulse_r <= pulse_s;
`endif
        end
    end

    assign key_onehot  = key_onehot_r;
    assign key_en      = key_en_r;
    assign press_pulse = press_pulse_r;
    assign key_state   = state_r;

endmodule

// File: tb/tb_key8_debounce_onehot.sv
// Directed bench for key8_debounce_onehot with DEB_CYCLES=4, REPEAT_CYCLES=6.
// Expected values are hand-derived edge counts from the point key_raw changes.
module tb_key8_debounce_onehot;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_raw;
    logic [7:0] key_onehot;
    logic       key_en;
    logic       press_pulse;
    logic [1:0] key_state;

    int vectors;
    int miscompares;

    key8_debounce_onehot #(
        .DEB_CYCLES   (4),
        .REPEAT_CYCLES(6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw    (key_raw),
        .key_onehot (key_onehot),
        .key_en     (key_en),
        .press_pulse(press_pulse),
        .key_state  (key_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] oh, input logic en,
                           input logic pp, input logic [1:0] st);
        chk({tag, ".onehot"}, {24'd0, key_onehot}, {24'd0, oh});
        chk({tag, ".en"},     {31'd0, key_en},     {31'd0, en});
        chk({tag, ".pulse"},  {31'd0, press_pulse}, {31'd0, pp});
        chk({tag, ".state"},  {30'd0, key_state},  {30'd0, st});
    endtask

    // Apply a key right after an edge and step to the acceptance edge (edge 7).
    task automatic press(input string tag, input logic [7:0] k);
        key_raw = k;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk({tag, ".pre_en"}, {31'd0, key_en}, 32'd0);
        end
        tick();
        chk_out({tag, ".accept"}, k, 1'b1, 1'b1, 2'd2);
    endtask

    // Release all keys and step until IDLE is reached (edge 7 after release).
    task automatic release_all(input string tag);
        key_raw = 8'd0;
        for (int i = 1; i <= 7; i++) begin
            tick();
        end
        chk_out({tag, ".idle"}, 8'd0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        key_raw     = 8'h10;

        // 1: reset holds everything at zero even with a key present
        tick();
        chk_out("rst_e1", 8'd0, 1'b0, 1'b0, 2'd0);
        tick();
        chk_out("rst_e2", 8'd0, 1'b0, 1'b0, 2'd0);
        rst_n   = 1'b1;
        key_raw = 8'd0;
        tick();
        tick();
        tick();
        chk_out("post_rst", 8'd0, 1'b0, 1'b0, 2'd0);

        // 2: clean press of 8'h04, EN at edge 7, single pulse
        press("t2", 8'h04);
        for (int i = 8; i <= 27; i++) begin
            tick();
            chk("t2.held_en", {31'd0, key_en}, 32'd1);
            chk("t2.held_oh", {24'd0, key_onehot}, 32'h04);
`ifdef KEY_REPEAT_EN
            chk("t2.rep_pulse", {31'd0, press_pulse}, {31'd0, ((i - 7) % 6) == 0});
`else
            chk("t2.no_repeat", {31'd0, press_pulse}, 32'd0);
`endif
        end
        key_raw = 8'd0;
        tick();
        tick();
        chk("t2.rel_e2_en", {31'd0, key_en}, 32'd1);
        tick();
        chk_out("t2.rel_e3", 8'd0, 1'b0, 1'b0, 2'd3);
        tick();
        tick();
        tick();
        chk("t2.rel_e6_st", {30'd0, key_state}, 32'd3);
        tick();
        chk("t2.rel_e7_st", {30'd0, key_state}, 32'd0);

        // 3: three-cycle bounce never reaches HELD
        key_raw = 8'h04;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) key_raw = 8'd0;
            chk("t3.en", {31'd0, key_en}, 32'd0);
            chk("t3.pulse", {31'd0, press_pulse}, 32'd0);
            if (i == 4) chk("t3.deb_st", {30'd0, key_state}, 32'd1);
            if (i == 6) chk("t3.back_idle", {30'd0, key_state}, 32'd0);
        end

        // 4: extra key while held forces RELEASE; full release before next accept
        press("t4a", 8'h01);
        key_raw = 8'h03;
        tick();
        tick();
        chk("t4.e2_en", {31'd0, key_en}, 32'd1);
        tick();
        chk_out("t4.e3", 8'd0, 1'b0, 1'b0, 2'd3);
        key_raw = 8'd0;
        for (int i = 4; i <= 8; i++) begin
            tick();
            chk("t4.rel_st", {30'd0, key_state}, 32'd3);
        end
        tick();
        chk("t4.e9_idle", {30'd0, key_state}, 32'd0);
        press("t4b", 8'h02);
        release_all("t4b");

        // 5: two keys at once are ignored
        key_raw = 8'h81;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("t5.en", {31'd0, key_en}, 32'd0);
            chk("t5.st", {30'd0, key_state}, 32'd0);
        end
        key_raw = 8'd0;
        tick();
        tick();
        tick();

        // 6: reset while HELD drops the key at that edge
        press("t6", 8'h80);
        tick();
        tick();
        chk("t6.held", {24'd0, key_onehot}, 32'h80);
        rst_n = 1'b0;
        tick();
        chk_out("t6.rst", 8'd0, 1'b0, 1'b0, 2'd0);
        rst_n   = 1'b1;
        key_raw = 8'd0;
        tick();
        chk_out("t6.after", 8'd0, 1'b0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
